bot_upd_ctrl: RTL and testbench
===============================

BOT_UPD_CTRL -- requirements
Module: bot_upd_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for bot_upd_async (legal 2..4).
REQ-002 SHALL have parameter STABLE_MAX, default 8: maximum SETTLE sample cycles before a forced capture.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 32'd1000000: PENDING cycles before timeout.
REQ-004 SHALL have parameter SAFE_MOTCTL, default 8'h00: motor command driven while timed out.
REQ-005 HCLK  in  1  sole clock; all state changes on its rising edge.
REQ-006 HRESETn  in  1  asynchronous, active-low reset.
REQ-007 bot_upd_async  in  1  update pulse from the rojobot domain, asynchronous to HCLK; the source guarantees a width of at least 1.5 HCLK periods.
REQ-008 bot_info_in  in  32  {LocX, LocY, Sensors, BotInfo}, asynchronous and multi-bit.
REQ-009 cpu_ack  in  1  one-cycle acknowledge pulse from the AHB interrupt-ack register write.
REQ-010 cpu_motctl_we  in  1  motor-control write strobe.
REQ-011 cpu_motctl_wdata  in  8  motor-control write data.
REQ-012 botinfo_snap  out  32  last stable snapshot of bot_info_in.
REQ-013 bot_updt  out  1  update-pending flag to the CPU port.
REQ-014 overrun_cnt  out  8  count of updates received while pending, saturating.
REQ-015 ack_timeout  out  1  sticky timeout flag.
REQ-016 motctl_out  out  8  motor command to the rojobot.

Function
REQ-017 SHALL pass bot_upd_async through a SYNC_STAGES flip-flop chain, then a rising-edge detector; the result is upd_edge, a one-cycle pulse.
REQ-018 SHALL implement three states: IDLE, SETTLE, PENDING.
REQ-019 IDLE: on upd_edge, SHALL go to SETTLE, load samp_prev <= bot_info_in and clear stab_cnt.
REQ-020 SETTLE: each cycle SHALL sample bot_info_in and increment stab_cnt.
- If sample == samp_prev: snapshot <= sample, then go to PENDING.
- Else, if stab_cnt == STABLE_MAX-1: snapshot <= sample (forced capture), then go to PENDING.
- Else: samp_prev <= sample, stay in SETTLE.
REQ-021 On entry to PENDING, bot_updt SHALL be 1 in the cycle after the snapshot write, and the timeout counter SHALL clear.
REQ-022 PENDING: the timeout counter SHALL increment every cycle; on reaching ACK_TIMEOUT-1, ack_timeout SHALL set and the counter SHALL hold.
REQ-023 PENDING, cpu_ack=1: SHALL clear bot_updt, ack_timeout and the timeout counter, and go to IDLE.
REQ-024 PENDING, upd_edge=1 and cpu_ack=0: overrun_cnt SHALL increment, saturating at 8'hFF, and the block SHALL go to SETTLE.
- bot_updt stays 1 through SETTLE.
- ack_timeout stays unchanged.
REQ-025 cpu_ack and upd_edge in the same cycle in PENDING: the ack SHALL take effect and the block SHALL go to SETTLE with bot_updt=0; no overrun is counted.
REQ-026 cpu_ack in IDLE SHALL be ignored.
REQ-027 cpu_ack in SETTLE SHALL clear bot_updt and ack_timeout; SETTLE continues, and its capture re-asserts bot_updt.
REQ-028 upd_edge while in SETTLE SHALL be ignored; the ongoing capture already samples the newest data.
REQ-029 botinfo_snap SHALL change only on a SETTLE capture.
REQ-030 overrun_cnt SHALL clear only on reset.
REQ-031 cpu_motctl_we=1 SHALL load the motor-control register from cpu_motctl_wdata on the next edge, in any state.
REQ-032 motctl_out SHALL equal SAFE_MOTCTL while ack_timeout=1, and the motor-control register otherwise; the register value is retained across a timeout.
REQ-033 Latency from a synchronized upd_edge with stable data to bot_updt=1 SHALL be 2 HCLK cycles; from bot_upd_async rising, it is SYNC_STAGES+3 cycles worst case.

Reset
REQ-034 HRESETn=0 SHALL immediately, asynchronously, force the following:
- state=IDLE
- synchronizer and edge-detector flops = 0
- botinfo_snap=0, bot_updt=0, overrun_cnt=0, ack_timeout=0
- motor-control register=8'h00, timeout counter=0, stab_cnt=0
REQ-035 Reset asserted mid-SETTLE or mid-PENDING SHALL abandon the capture; no pending flag survives.
REQ-036 After deassertion, a bot_upd_async held high through reset SHALL NOT generate upd_edge.

Verification
REQ-037 Stable data: bot_info_in=32'h1234_5678, then pulse bot_upd_async -> botinfo_snap=32'h1234_5678 and bot_updt=1 within SYNC_STAGES+3 cycles; cpu_ack pulse -> bot_updt=0 next cycle, state IDLE.
REQ-038 Changing data: bot_info_in changes every cycle during SETTLE -> forced capture after STABLE_MAX=8 samples; bot_updt=1; snapshot equals the 8th sample.
REQ-039 Overrun: two updates with no ack -> overrun_cnt=1, bot_updt stays 1; 300 unacked updates -> overrun_cnt=8'hFF.
REQ-040 Timeout: ACK_TIMEOUT=16, motctl written 8'hA5, update left unacked -> after 16 PENDING cycles ack_timeout=1 and motctl_out=8'h00; cpu_ack -> motctl_out=8'hA5.
REQ-041 Collision: cpu_ack and upd_edge in the same PENDING cycle -> bot_updt=0 for one or more cycles, overrun_cnt unchanged, new snapshot captured.
REQ-042 Reset mid-SETTLE with bot_upd_async held 1 -> all outputs 0 immediately; no bot_updt after release until a new rising edge.

Source files
------------

// File: rtl/bot_upd_ctrl_if.sv
// Signal bundle between the rojobot/CPU side and the update controller.
// The master side drives the update pulse, bot data and CPU strobes; the
// slave side (the controller) returns the snapshot, flags and motor command.
interface bot_upd_ctrl_if;
    logic        bot_upd_async;
    logic [31:0] bot_info_in;
    logic        cpu_ack;
    logic        cpu_motctl_we;
    logic [7:0]  cpu_motctl_wdata;
    logic [31:0] botinfo_snap;
    logic        bot_updt;
    logic [7:0]  overrun_cnt;
    logic        ack_timeout;
    logic [7:0]  motctl_out;

    modport master (
        output bot_upd_async, bot_info_in, cpu_ack, cpu_motctl_we, cpu_motctl_wdata,
        input  botinfo_snap, bot_updt, overrun_cnt, ack_timeout, motctl_out
    );

    modport slave (
        input  bot_upd_async, bot_info_in, cpu_ack, cpu_motctl_we, cpu_motctl_wdata,
        output botinfo_snap, bot_updt, overrun_cnt, ack_timeout, motctl_out
    );
endinterface

// File: rtl/bot_upd_ctrl.sv
// Rojobot update controller: synchronizes the update pulse, captures a
// settled snapshot of the multi-bit bot data, raises a pending flag for the
// CPU, counts overruns and falls back to a safe motor command on ack timeout.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | no update outstanding, waiting for an update edge
//   ST_SETTLE  | sampling bot_info_in until two samples match (or forced)
//   ST_PENDING | snapshot held, waiting for the CPU ack; timeout running
module bot_upd_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_MAX  = 8,
    parameter logic [31:0] ACK_TIMEOUT = 32'd1000000,
    parameter logic [7:0]  SAFE_MOTCTL = 8'h00
) (
    input logic           HCLK,
    input logic           HRESETn,
    bot_upd_ctrl_if.slave bus
);

    localparam int unsigned   SW        = $clog2(STABLE_MAX + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_MAX - 1);
    localparam logic [31:0]   TO_LAST   = ACK_TIMEOUT - 32'd1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_PENDING} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [SYNC_STAGES:0]   r_vld;
    logic                   w_upd_edge;

    logic [31:0]   r_samp_prev, w_samp_prev_nxt;
    logic [SW-1:0] r_stab_cnt,  w_stab_cnt_nxt;
    logic [31:0]   r_snap,      w_snap_nxt;
    logic          r_updt,      w_updt_nxt;
    logic [7:0]    r_ovr,       w_ovr_nxt;
    logic          r_ack_to,    w_ack_to_nxt;
    logic [31:0]   r_to_cnt,    w_to_cnt_nxt;
    logic [7:0]    r_motctl;

    // Synchronizer chain plus edge detector; r_vld marks when the delayed
    // copy holds a genuine post-reset sample, so an input held high through
    // reset is never mistaken for a fresh rising edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_vld    <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.bot_upd_async};
            r_sync_d <= r_sync[SYNC_STAGES-1];
            r_vld    <= {r_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_upd_edge = r_vld[SYNC_STAGES] & r_sync[SYNC_STAGES-1] & ~r_sync_d;

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and datapath update decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_samp_prev_nxt = r_samp_prev;
        w_stab_cnt_nxt  = r_stab_cnt;
        w_snap_nxt      = r_snap;
        w_updt_nxt      = r_updt;
        w_ovr_nxt       = r_ovr;
        w_ack_to_nxt    = r_ack_to;
        w_to_cnt_nxt    = r_to_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_upd_edge) begin
                    w_state_nxt     = ST_SETTLE;
                    w_samp_prev_nxt = bus.bot_info_in;
                    w_stab_cnt_nxt  = '0;
                end
            end
            ST_SETTLE: begin
                w_stab_cnt_nxt = r_stab_cnt + SW'(1);
                if (bus.cpu_ack) begin
                    w_updt_nxt   = 1'b0;
                    w_ack_to_nxt = 1'b0;
                end
                if (bus.bot_info_in == r_samp_prev || r_stab_cnt == STAB_LAST) begin
                    w_snap_nxt   = bus.bot_info_in;
                    w_updt_nxt   = 1'b1;
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = ST_PENDING;
                end else begin
                    w_samp_prev_nxt = bus.bot_info_in;
                end
            end
            ST_PENDING: begin
                if (bus.cpu_ack) begin
                    w_updt_nxt   = 1'b0;
                    w_ack_to_nxt = 1'b0;
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                    if (w_upd_edge) begin
                        w_state_nxt     = ST_SETTLE;
                        w_samp_prev_nxt = bus.bot_info_in;
                        w_stab_cnt_nxt  = '0;
                    end
                end else if (w_upd_edge) begin
                    if (r_ovr != 8'hFF) w_ovr_nxt = r_ovr + 8'd1;
                    w_state_nxt     = ST_SETTLE;
                    w_samp_prev_nxt = bus.bot_info_in;
                    w_stab_cnt_nxt  = '0;
                end else if (r_to_cnt == TO_LAST) begin
                    w_ack_to_nxt = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 32'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers; the motor register loads on any write strobe.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_samp_prev <= '0;
            r_stab_cnt  <= '0;
            r_snap      <= '0;
            r_updt      <= 1'b0;
            r_ovr       <= '0;
            r_ack_to    <= 1'b0;
            r_to_cnt    <= '0;
            r_motctl    <= 8'h00;
        end else begin
            r_samp_prev <= w_samp_prev_nxt;
            r_stab_cnt  <= w_stab_cnt_nxt;
            r_snap      <= w_snap_nxt;
            r_updt      <= w_updt_nxt;
            r_ovr       <= w_ovr_nxt;
            r_ack_to    <= w_ack_to_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            if (bus.cpu_motctl_we) r_motctl <= bus.cpu_motctl_wdata;
        end
    end

    assign bus.botinfo_snap = r_snap;
    assign bus.bot_updt     = r_updt;
    assign bus.overrun_cnt  = r_ovr;
    assign bus.ack_timeout  = r_ack_to;
    assign bus.motctl_out   = r_ack_to ? SAFE_MOTCTL : r_motctl;

endmodule

// File: tb/tb_bot_upd_ctrl.sv
// Directed bench for bot_upd_ctrl. Stimulus posts time-stamped expectations
// into a queue; a monitor on the falling clock edge compares them when due.
module tb_bot_upd_ctrl;

    localparam int SNAP = 0, UPD = 1, OVR = 2, ATO = 3, MOT = 4;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    bot_upd_ctrl_if bus();

    bot_upd_ctrl #(
        .SYNC_STAGES(2),
        .STABLE_MAX (8),
        .ACK_TIMEOUT(32'd16),
        .SAFE_MOTCTL(8'h00)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge HCLK) begin
        logic [31:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                case (q[i].sel)
                    SNAP:    act = bus.botinfo_snap;
                    UPD:     act = {31'd0, bus.bot_updt};
                    OVR:     act = {24'd0, bus.overrun_cnt};
                    ATO:     act = {31'd0, bus.ack_timeout};
                    default: act = {24'd0, bus.motctl_out};
                endcase
                n_cmp++;
                if (q[i].due < cyc || act !== q[i].exp) begin
                    n_err++;
                    $display("FAIL %s: got %0h expected %0h (cycle %0d, due %0d)",
                             q[i].nm, act, q[i].exp, cyc, q[i].due);
                end
                q.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic expect_abs(input int due, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.due = due; e.sel = sel; e.exp = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic upd_pulse();
        bus.bot_upd_async = 1'b1;
        tick(2);
        bus.bot_upd_async = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.cpu_ack = 1'b1;
        tick(1);
        bus.cpu_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        HRESETn              = 1'b0;
        bus.bot_upd_async    = 1'b0;
        bus.bot_info_in      = '0;
        bus.cpu_ack          = 1'b0;
        bus.cpu_motctl_we    = 1'b0;
        bus.cpu_motctl_wdata = '0;

        // Reset state
        tick(1);
        n_cmp++;
        if (bus.botinfo_snap !== 32'h0) begin
            n_err++;
            $display("FAIL rst_snap_direct: got %0h expected 0", bus.botinfo_snap);
        end
        n_cmp++;
        if (bus.bot_updt !== 1'b0) begin
            n_err++;
            $display("FAIL rst_updt_direct: got %0b expected 0", bus.bot_updt);
        end
        n_cmp++;
        if (bus.overrun_cnt !== 8'h00) begin
            n_err++;
            $display("FAIL rst_ovr_direct: got %0h expected 0", bus.overrun_cnt);
        end
        n_cmp++;
        if (bus.ack_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ato_direct: got %0b expected 0", bus.ack_timeout);
        end
        n_cmp++;
        if (bus.motctl_out !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mot_direct: got %0h expected 0", bus.motctl_out);
        end
        expect_abs(cyc, SNAP, 0, "rst_snap");
        expect_abs(cyc, UPD,  0, "rst_updt");
        expect_abs(cyc, OVR,  0, "rst_ovr");
        expect_abs(cyc, ATO,  0, "rst_ato");
        expect_abs(cyc, MOT,  0, "rst_mot");
        tick(2);
        HRESETn = 1'b1;
        tick(5);

        // Stable data capture and ack
        c = cyc;
        bus.bot_info_in = 32'h1234_5678;
        expect_abs(c + 3, UPD, 0, "t1_updt_pre");
        expect_abs(c + 4, UPD, 1, "t1_updt");
        expect_abs(c + 4, SNAP, 32'h1234_5678, "t1_snap");
        upd_pulse();
        tick(2);
        ack_pulse();
        expect_abs(cyc, UPD, 0, "t1_ack_clr");
        ack_pulse();
        expect_abs(cyc + 2, UPD, 0, "t1_idle_ack_ignored");
        tick(3);

        // Two updates without ack -> one overrun
        c = cyc;
        bus.bot_info_in = 32'hCAFE_0001;
        expect_abs(c + 4,  UPD,  1, "t2_updt_first");
        expect_abs(c + 8,  SNAP, 32'hCAFE_0001, "t2_snap_held");
        expect_abs(c + 9,  OVR,  1, "t2_ovr");
        expect_abs(c + 9,  UPD,  1, "t2_updt_settle");
        expect_abs(c + 10, UPD,  1, "t2_updt_second");
        expect_abs(c + 10, SNAP, 32'hCAFE_0002, "t2_snap_second");
        upd_pulse();
        tick(4);
        bus.bot_info_in = 32'hCAFE_0002;
        upd_pulse();
        tick(2);
        ack_pulse();
        expect_abs(cyc, UPD, 0, "t2_ack_clr");
        tick(3);

        // Ack and update edge in the same PENDING cycle
        c = cyc;
        bus.bot_info_in = 32'h1111_1111;
        expect_abs(c + 4,  UPD,  1, "t4_updt_first");
        expect_abs(c + 9,  UPD,  0, "t4_updt_coll");
        expect_abs(c + 9,  OVR,  1, "t4_ovr_coll");
        expect_abs(c + 10, UPD,  1, "t4_updt_recapt");
        expect_abs(c + 10, SNAP, 32'h2222_2222, "t4_snap_recapt");
        expect_abs(c + 11, OVR,  1, "t4_ovr_after");
        upd_pulse();
        tick(4);
        bus.bot_info_in = 32'h2222_2222;
        upd_pulse();
        ack_pulse();
        tick(2);
        ack_pulse();
        expect_abs(cyc, UPD, 0, "t4_ack_clr");
        tick(3);

        // Data changing every cycle -> forced capture of the 8th sample
        c = cyc;
        expect_abs(c + 5,  SNAP, 32'h2222_2222, "t3_snap_unchanged");
        expect_abs(c + 10, UPD,  0, "t3_updt_pre");
        expect_abs(c + 11, UPD,  1, "t3_updt_forced");
        expect_abs(c + 11, SNAP, 32'hA5A5_000A, "t3_snap_forced");
        for (int i = 0; i < 14; i++) begin
            bus.bot_info_in   = 32'hA5A5_0000 + 32'(i);
            bus.bot_upd_async = (i < 2);
            tick(1);
        end
        ack_pulse();
        expect_abs(cyc, UPD, 0, "t3_ack_clr");
        tick(3);

        // Many unacked updates -> saturating overrun count
        bus.bot_info_in = 32'h0BAD_F00D;
        for (int n = 0; n < 300; n++) begin
            upd_pulse();
            tick(4);
            if (n == 99)  expect_abs(cyc, OVR, 8'h64, "t5_ovr_100");
            if (n == 253) expect_abs(cyc, OVR, 8'hFE, "t5_ovr_254");
        end
        expect_abs(cyc, OVR, 8'hFF, "t5_ovr_sat");
        expect_abs(cyc, UPD, 1, "t5_updt_held");
        ack_pulse();
        expect_abs(cyc, UPD, 0, "t5_ack_clr");
        expect_abs(cyc, OVR, 8'hFF, "t5_ovr_kept");
        tick(3);

        // Ack timeout forces the safe motor command
        bus.cpu_motctl_we    = 1'b1;
        bus.cpu_motctl_wdata = 8'hA5;
        tick(1);
        bus.cpu_motctl_we    = 1'b0;
        expect_abs(cyc, MOT, 8'hA5, "t6_mot_written");
        c = cyc;
        bus.bot_info_in = 32'h7777_0000;
        expect_abs(c + 4,  UPD, 1, "t6_updt");
        expect_abs(c + 19, ATO, 0, "t6_ato_pre");
        expect_abs(c + 19, MOT, 8'hA5, "t6_mot_pre");
        expect_abs(c + 20, ATO, 1, "t6_ato_set");
        expect_abs(c + 20, MOT, 8'h00, "t6_mot_safe");
        expect_abs(c + 22, ATO, 1, "t6_ato_sticky");
        upd_pulse();
        tick(20);
        ack_pulse();
        expect_abs(cyc, ATO, 0, "t6_ato_clr");
        expect_abs(cyc, MOT, 8'hA5, "t6_mot_restored");
        expect_abs(cyc, UPD, 0, "t6_updt_clr");
        tick(3);

        // Reset mid-SETTLE with the update input held high
        c = cyc;
        bus.bot_info_in = 32'h3333_0000;
        expect_abs(c + 4, UPD, 1, "t7_updt_first");
        upd_pulse();
        tick(4);
        expect_abs(c + 10, UPD, 1, "t7_updt_in_settle");
        expect_abs(c + 10, OVR, 8'hFF, "t7_ovr_pre");
        bus.bot_upd_async = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.bot_info_in = 32'h4444_0000 + 32'(i);
            tick(1);
        end
        HRESETn = 1'b0;
        #1;
        n_cmp++;
        if (bus.bot_updt !== 1'b0) begin
            n_err++;
            $display("FAIL t7_rst_updt_async: got %0b expected 0", bus.bot_updt);
        end
        n_cmp++;
        if (bus.overrun_cnt !== 8'h00) begin
            n_err++;
            $display("FAIL t7_rst_ovr_async: got %0h expected 0", bus.overrun_cnt);
        end
        n_cmp++;
        if (bus.botinfo_snap !== 32'h0) begin
            n_err++;
            $display("FAIL t7_rst_snap_async: got %0h expected 0", bus.botinfo_snap);
        end
        expect_abs(cyc, SNAP, 0, "t7_rst_snap");
        expect_abs(cyc, UPD,  0, "t7_rst_updt");
        expect_abs(cyc, OVR,  0, "t7_rst_ovr");
        expect_abs(cyc, ATO,  0, "t7_rst_ato");
        expect_abs(cyc, MOT,  0, "t7_rst_mot");
        tick(2);
        HRESETn = 1'b1;
        expect_abs(cyc + 3,  UPD, 0, "t7_no_edge_a");
        expect_abs(cyc + 7,  UPD, 0, "t7_no_edge_b");
        expect_abs(cyc + 12, UPD, 0, "t7_no_edge_c");
        tick(13);
        bus.bot_upd_async = 1'b0;
        tick(3);
        c = cyc;
        bus.bot_info_in = 32'h5555_5555;
        expect_abs(c + 4, UPD,  1, "t7_new_edge_updt");
        expect_abs(c + 4, SNAP, 32'h5555_5555, "t7_new_edge_snap");
        upd_pulse();
        tick(4);

        tick(3);
        foreach (q[i]) begin
            n_err++;
            $display("FAIL %s: got unchecked expected checked (due %0d)", q[i].nm, q[i].due);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
